// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal-sync tree node.
//   err_code_e   : error classification reported on err_code_o alongside err_o
//   port_state_e : per-child-port request FSM state
//   N_PORTS      : number of child ports served by one node
package fractal_sync_pkg;

  localparam int N_PORTS = 2;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_ID   = 2'd1,
    ERR_SIG  = 2'd2,
    ERR_LVL  = 2'd3
  } err_code_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } port_state_e;

endpackage

// File: rtl/fractal_sync_mw_fifo.sv
// Two-write / one-read FIFO.
//   clk_i, rst_ni          : clock, async active-low reset (empties the queue)
//   wr0_en_i/wr0_data_i    : first write port, lands ahead of wr1 in the same cycle
//   wr1_en_i/wr1_data_i    : second write port
//   rd_valid_o/rd_ready_i  : read handshake, rd_data_o is the head entry
//   free_o                 : number of free slots this cycle (before any push/pop)
// Writers must not push more entries than free_o allows; a push and a pop in the
// same cycle on a full queue is fine because the head is read before it is reused.
module fractal_sync_mw_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr0_en_i,
  input  logic [WIDTH-1:0] wr0_data_i,
  input  logic             wr1_en_i,
  input  logic [WIDTH-1:0] wr1_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]    free_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic [PW-1:0]    w_wptr1;
  logic [PW-1:0]    w_wptr2;
  logic [PW-1:0]    w_wr1_idx;
  logic             w_pop;
  logic [CW-1:0]    w_n_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign rd_valid_o = (r_count != '0);
  assign rd_data_o  = r_mem[r_rptr];
  assign free_o     = CW'(DEPTH) - r_count;

  assign w_pop     = rd_valid_o && rd_ready_i;
  assign w_wptr1   = ptr_inc(r_wptr);
  assign w_wptr2   = ptr_inc(w_wptr1);
  // wr1 compacts into the tail slot when wr0 is idle.
  assign w_wr1_idx = wr0_en_i ? w_wptr1 : r_wptr;
  assign w_n_wr    = CW'(wr0_en_i) + CW'(wr1_en_i);

  always_ff @(posedge clk_i) begin
    if (wr0_en_i) r_mem[r_wptr]    <= wr0_data_i;
    if (wr1_en_i) r_mem[w_wr1_idx] <= wr1_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (wr0_en_i && wr1_en_i)      r_wptr <= w_wptr2;
      else if (wr0_en_i || wr1_en_i) r_wptr <= w_wptr1;
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      r_count <= r_count + w_n_wr - CW'(w_pop);
    end
  end

endmodule

// File: rtl/fractal_sync_1d_rf_master.sv
// Initiator side of the 1D sync RF check interface of one fractal-sync tree node.
//   clk_i, rst_ni                     : clock, async active-low reset
//   req_valid_i/req_ready_o, req_level_i, req_id_i : barrier requests from the child ports
//   level_o, id_o                     : staged request presented to the RF
//   check_local_o, check_remote_o     : one-cycle RF check strobes
//   present/bypass/ignore_{local,remote}_i, id_err_i, sig_err_i : RF result, same cycle as check
//   up_valid_o/up_ready_i, up_level_o, up_id_o      : completions toward the parent
//   dn_valid_i/dn_ready_o, dn_level_i, dn_id_i      : wakes arriving from the parent
//   wake_valid_o/wake_ready_i, wake_level_o, wake_id_o : wakes broadcast to the children
//   err_o, err_code_o                 : per-port error pulse and its code
//   dbg_issue_o                       : per-port FSM state (1 = ISSUE)
// All valid/ready channels: a beat transfers when valid && ready; the producer keeps
// valid and data stable until that happens.
module fractal_sync_1d_rf_master
  import fractal_sync_pkg::*;
#(
  parameter int NODE_LEVEL  = 0,
  parameter int LEVEL_WIDTH = 1,
  parameter int ID_WIDTH    = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [N_PORTS-1:0]                    req_valid_i,
  output logic [N_PORTS-1:0]                    req_ready_o,
  input  logic [N_PORTS-1:0][LEVEL_WIDTH-1:0]   req_level_i,
  input  logic [N_PORTS-1:0][ID_WIDTH-1:0]      req_id_i,
  output logic [N_PORTS-1:0][LEVEL_WIDTH-1:0]   level_o,
  output logic [N_PORTS-1:0][ID_WIDTH-1:0]      id_o,
  output logic [N_PORTS-1:0]                    check_local_o,
  output logic [N_PORTS-1:0]                    check_remote_o,
  input  logic [N_PORTS-1:0]                    present_local_i,
  input  logic [N_PORTS-1:0]                    present_remote_i,
  input  logic [N_PORTS-1:0]                    bypass_local_i,
  input  logic [N_PORTS-1:0]                    bypass_remote_i,
  input  logic [N_PORTS-1:0]                    ignore_local_i,
  input  logic [N_PORTS-1:0]                    ignore_remote_i,
  input  logic [N_PORTS-1:0]                    id_err_i,
  input  logic [N_PORTS-1:0]                    sig_err_i,
  output logic                                  up_valid_o,
  input  logic                                  up_ready_i,
  output logic [LEVEL_WIDTH-1:0]                up_level_o,
  output logic [ID_WIDTH-1:0]                   up_id_o,
  input  logic                                  dn_valid_i,
  output logic                                  dn_ready_o,
  input  logic [LEVEL_WIDTH-1:0]                dn_level_i,
  input  logic [ID_WIDTH-1:0]                   dn_id_i,
  output logic                                  wake_valid_o,
  input  logic                                  wake_ready_i,
  output logic [LEVEL_WIDTH-1:0]                wake_level_o,
  output logic [ID_WIDTH-1:0]                   wake_id_o,
  output logic [N_PORTS-1:0]                    err_o,
  output logic [N_PORTS-1:0][1:0]               err_code_o,
  output logic [N_PORTS-1:0]                    dbg_issue_o
);

  localparam int PLW = LEVEL_WIDTH + ID_WIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  port_state_e                         r_state     [N_PORTS];
  port_state_e                         w_state_nxt [N_PORTS];
  logic [N_PORTS-1:0][LEVEL_WIDTH-1:0] r_level;
  logic [N_PORTS-1:0][ID_WIDTH-1:0]    r_id;

  logic [N_PORTS-1:0] w_lvl_low;
  logic [N_PORTS-1:0] w_is_local;
  logic [N_PORTS-1:0] w_hit;
  logic [N_PORTS-1:0] w_done;
  logic [N_PORTS-1:0] w_capture;
  logic [N_PORTS-1:0] w_push_local;
  logic [N_PORTS-1:0] w_push_remote;

  logic [CW-1:0]  w_up_free;
  logic [CW-1:0]  w_wake_free;
  logic           w_dn_acc;
  logic           w_wake_wr0;
  logic [PLW-1:0] w_wake_d0;
  logic [PLW-1:0] w_up_rd;
  logic [PLW-1:0] w_wake_rd;

  assign level_o    = r_level;
  assign id_o       = r_id;
  assign dn_ready_o = (w_wake_free != '0);
  assign w_dn_acc   = dn_valid_i && dn_ready_o;

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      w_state_nxt[p]    = r_state[p];
      w_done[p]         = 1'b0;
      w_capture[p]      = 1'b0;
      w_push_local[p]   = 1'b0;
      w_push_remote[p]  = 1'b0;
      req_ready_o[p]    = 1'b0;
      check_local_o[p]  = 1'b0;
      check_remote_o[p] = 1'b0;
      err_o[p]          = 1'b0;
      err_code_o[p]     = ERR_NONE;
      dbg_issue_o[p]    = (r_state[p] == ISSUE);

      w_lvl_low[p]  = int'(r_level[p]) < NODE_LEVEL;
      w_is_local[p] = int'(r_level[p]) == NODE_LEVEL;
      w_hit[p]      = w_is_local[p]
                    ? ((present_local_i[p]  | bypass_local_i[p])  & ~ignore_local_i[p])
                    : ((present_remote_i[p] | bypass_remote_i[p]) & ~ignore_remote_i[p]);

      if (r_state[p] == IDLE) begin
        req_ready_o[p] = 1'b1;
      end else begin
        if (w_lvl_low[p]) begin
          err_o[p]      = 1'b1;
          err_code_o[p] = ERR_LVL;
          w_done[p]     = 1'b1;
        // Two free slots per issuer keep both ports safe when they hit the same
        // queue in one cycle; a local issue also yields to an accepted dn beat.
        end else if (w_is_local[p]) begin
          if ((w_wake_free >= CW'(2)) && !w_dn_acc) begin
            check_local_o[p] = 1'b1;
            w_done[p]        = 1'b1;
          end
        end else if (w_up_free >= CW'(2)) begin
          check_remote_o[p] = 1'b1;
          w_done[p]         = 1'b1;
        end

        if (check_local_o[p] || check_remote_o[p]) begin
          if (id_err_i[p]) begin
            err_o[p]      = 1'b1;
            err_code_o[p] = ERR_ID;
          end else if (sig_err_i[p]) begin
            err_o[p]      = 1'b1;
            err_code_o[p] = ERR_SIG;
          end else if (w_hit[p]) begin
            w_push_local[p]  = w_is_local[p];
            w_push_remote[p] = ~w_is_local[p];
          end
        end
        req_ready_o[p] = w_done[p];
      end

      if (req_ready_o[p] && req_valid_i[p]) begin
        w_capture[p]   = 1'b1;
        w_state_nxt[p] = ISSUE;
      end else if (w_done[p]) begin
        w_state_nxt[p] = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < N_PORTS; p++) r_state[p] <= IDLE;
      r_level <= '0;
      r_id    <= '0;
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        r_state[p] <= w_state_nxt[p];
        if (w_capture[p]) begin
          r_level[p] <= req_level_i[p];
          r_id[p]    <= req_id_i[p];
        end
      end
    end
  end

  // The dn beat takes write slot 0; it never coincides with a local push from either port.
  assign w_wake_wr0 = w_dn_acc | w_push_local[0];
  assign w_wake_d0  = w_dn_acc ? {dn_level_i, dn_id_i} : {r_level[0], r_id[0]};

  fractal_sync_mw_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PLW)
  ) u_up_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr0_en_i   (w_push_remote[0]),
    .wr0_data_i ({r_level[0], r_id[0]}),
    .wr1_en_i   (w_push_remote[1]),
    .wr1_data_i ({r_level[1], r_id[1]}),
    .rd_valid_o (up_valid_o),
    .rd_ready_i (up_ready_i),
    .rd_data_o  (w_up_rd),
    .free_o     (w_up_free)
  );

  fractal_sync_mw_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PLW)
  ) u_wake_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr0_en_i   (w_wake_wr0),
    .wr0_data_i (w_wake_d0),
    .wr1_en_i   (w_push_local[1]),
    .wr1_data_i ({r_level[1], r_id[1]}),
    .rd_valid_o (wake_valid_o),
    .rd_ready_i (wake_ready_i),
    .rd_data_o  (w_wake_rd),
    .free_o     (w_wake_free)
  );

  assign {up_level_o, up_id_o}     = w_up_rd;
  assign {wake_level_o, wake_id_o} = w_wake_rd;

endmodule
